// File: rtl/ad_scan_ctrl.sv
// ad_scan_ctrl: master-side scan sequencer for a 3-wire serial ADC.
//   Drives the 4:1 analog mux select and the chip-select, and generates adclk.
//   Each scan visits every channel latched from ch_en_i once, lowest index first.
//   For each channel it shifts in 8 bits, MSB first, and presents the result
//   with a single-cycle data_valid_o strobe.
// Ports:
//   clk_i, rst_i    system clock; synchronous active-high reset
//   auto_i          enables the free-running period timer as a trigger source
//   start_i         single-cycle scan request
//   ch_en_i[3:0]    channel enable mask, sampled when a scan is accepted
//   ad_o[1:0]       {adcsn (active-low), adclk}
//   addat_i         ADC serial data
//   ch_sel_o[1:0]   analog mux select
//   data_o, data_ch_o, data_valid_o   captured sample, its channel, and the strobe
//   busy_o          high while a scan is in progress
//   overrun_o       one-cycle pulse for a trigger that was dropped while busy
//
// state  | meaning
// IDLE   | waiting for a trigger
// SETL   | mux select settling before adcsn falls
// SHIFT  | adcsn low, toggling adclk and shifting in 8 bits
// DONE   | publish sample, then advance to next channel or return to IDLE
module ad_scan_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int SETTLE  = 8,
  parameter int PERIOD  = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       auto_i,
  input  logic       start_i,
  input  logic [3:0] ch_en_i,
  output logic [1:0] ad_o,
  input  logic       addat_i,
  output logic [1:0] ch_sel_o,
  output logic [7:0] data_o,
  output logic [1:0] data_ch_o,
  output logic       data_valid_o,
  output logic       busy_o,
  output logic       overrun_o
);

  typedef enum logic [1:0] {IDLE, SETL, SHIFT, DONE} state_e;

  localparam logic [7:0]  SETTLE_L = 8'(SETTLE);
  localparam logic [7:0]  DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [15:0] PER_M1   = 16'(PERIOD - 1);

  state_e      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  cnt_q, cnt_d;      // settle count in SETL, half-period count in SHIFT
  logic [3:0]  half_q, half_d;    // adclk half-period index within a frame
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  ch_q, ch_d;
  logic        csn_q, csn_d;
  logic        sclk_q, sclk_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  dch_q, dch_d;
  logic        dv_q, dv_d;
  logic        ovr_q, ovr_d;

  logic        expire, trig, nxt_ok;
  logic [1:0]  first_ch, nxt_ch;

  always_comb begin
    expire = auto_i && (tmr_q == PER_M1);
    // start and a coincident expiry merge into a single trigger
    trig   = start_i || expire;

    first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_en_i[i]) first_ch = 2'(i);
    end
    nxt_ok = 1'b0;
    nxt_ch = ch_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ok = 1'b1;
        nxt_ch = 2'(i);
      end
    end

    state_d = state_q;
    tmr_d   = !auto_i ? 16'd0 : (expire ? 16'd0 : tmr_q + 16'd1);
    cnt_d   = cnt_q;
    half_d  = half_q;
    sh_d    = sh_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    data_d  = data_q;
    dch_d   = dch_q;
    dv_d    = 1'b0;
    ovr_d   = trig && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (trig && (ch_en_i != 4'd0)) begin
          mask_d  = ch_en_i;
          ch_d    = first_ch;
          cnt_d   = SETTLE_L;
          state_d = SETL;
        end
      end
      SETL: begin
        if (cnt_q == 8'd0) begin
          csn_d   = 1'b0;
          cnt_d   = DIV_M1;
          half_d  = 4'd0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d  = DIV_M1;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            // data is captured on the edge that raises adclk
            sclk_d = 1'b1;
            sh_d   = {sh_q[6:0], addat_i};
          end else begin
            sclk_d = 1'b0;
            if (half_q == 4'd15) begin
              csn_d   = 1'b1;
              state_d = DONE;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        data_d = sh_q;
        dch_d  = ch_q;
        dv_d   = 1'b1;
        if (nxt_ok) begin
          ch_d    = nxt_ch;
          cnt_d   = SETTLE_L;
          state_d = SETL;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmr_q   <= 16'd0;
      cnt_q   <= 8'd0;
      half_q  <= 4'd0;
      sh_q    <= 8'd0;
      mask_q  <= 4'd0;
      ch_q    <= 2'd0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      data_q  <= 8'd0;
      dch_q   <= 2'd0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sh_q    <= sh_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      dch_q   <= dch_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ad_o         = {csn_q, sclk_q};
  assign ch_sel_o     = ch_q;
  assign data_o       = data_q;
  assign data_ch_o    = dch_q;
  assign data_valid_o = dv_q;
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_ad_scan_ctrl.sv
// tb_ad_scan_ctrl: directed scoreboard bench for ad_scan_ctrl.
//   Stimulus pushes expected {channel, sample} pairs into a queue; a monitor
//   pops and compares on every data_valid strobe and also checks frame shape
//   (adcsn low time, adclk edge count, strobe latency). A small ADC model
//   serialises a per-channel byte onto addat.
module tb_ad_scan_ctrl;
  localparam int CD  = 4;
  localparam int ST  = 8;
  localparam int PER = 50;

  logic       clk = 1'b0;
  logic       rst, auto_r, start, addat;
  logic [3:0] ch_en;
  logic [1:0] ad, ch_sel, data_ch;
  logic [7:0] data;
  logic       data_valid, busy, overrun;

  ad_scan_ctrl #(.CLK_DIV(CD), .SETTLE(ST), .PERIOD(PER)) dut (
    .clk_i(clk), .rst_i(rst), .auto_i(auto_r), .start_i(start), .ch_en_i(ch_en),
    .ad_o(ad), .addat_i(addat), .ch_sel_o(ch_sel), .data_o(data),
    .data_ch_o(data_ch), .data_valid_o(data_valid), .busy_o(busy),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ADC model
  logic [7:0] adc_val [4];
  int  bidx = 0;
  logic prev_sclk = 1'b0;
  always @(negedge clk) begin
    logic [7:0] cur;
    if (ad[1]) bidx = 0;
    else if (prev_sclk && !ad[0]) bidx++;
    prev_sclk = ad[0];
    cur = adc_val[ch_sel];
    addat = (bidx < 8) ? cur[7 - bidx] : 1'b0;
  end

  // Scoreboard and monitor
  logic [9:0] sbq[$];
  int   rise_cyc[$];
  int   fall_cyc = 0, low_cnt = 0, rises = 0;
  int   ovr_cnt = 0, dv_cnt = 0, viol = 0;
  logic [3:0] forbid = 4'd0;
  logic prev_sn = 1'b1, prev_ck = 1'b0, prev_busy = 1'b0, abort = 1'b0;
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) abort = 1'b1;
    if (ad[1] && ad[0]) viol++;
    if (busy && forbid[ch_sel]) viol++;
    if (prev_sn && !ad[1]) begin
      fall_cyc = cyc; low_cnt = 0; rises = 0; abort = 1'b0;
    end
    if (!ad[1]) begin
      low_cnt++;
      if (!prev_ck && ad[0]) rises++;
    end
    if (!prev_sn && ad[1] && !abort) begin
      check("csn_low_time", low_cnt, 16 * CD);
      check("sclk_rises", rises, 8);
    end
    if (data_valid) begin
      dv_cnt++;
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid got ch %0d data %0h expected none", data_ch, data);
      end else begin
        e = sbq.pop_front();
        check("data", data, e[7:0]);
        check("data_ch", data_ch, e[9:8]);
        check("valid_latency", cyc - fall_cyc, 16 * CD + 1);
      end
    end
    if (overrun) ovr_cnt++;
    if (busy && !prev_busy) rise_cyc.push_back(cyc);
    prev_sn = ad[1]; prev_ck = ad[0]; prev_busy = busy;
  end

  task automatic push(input logic [1:0] ch);
    sbq.push_back({ch, adc_val[ch]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < max; i++) begin
      if (!busy && sbq.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({name, "_done"}, ok, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, r0, o0, d0;
    adc_val[0] = 8'hA5; adc_val[1] = 8'h3C; adc_val[2] = 8'h5A; adc_val[3] = 8'hC3;
    rst = 1'b1; auto_r = 1'b0; start = 1'b0; ch_en = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ad", ad, 2'b10);
    check("rst_ch_sel", ch_sel, 2'd0);
    check("rst_data", data, 8'd0);
    check("rst_data_ch", data_ch, 2'd0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // 1: reset mid-SHIFT
    ch_en = 4'b0001;
    pulse_start();
    for (int i = 0; i < 100 && ad[1]; i++) @(negedge clk);
    check("t1_in_shift", ad[1], 1'b0);
    repeat (20) @(negedge clk);
    d0 = dv_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t1_ad_after_rst", ad, 2'b10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("t1_busy", busy, 1'b0);
    repeat (100) @(negedge clk);
    check("t1_data", data, 8'd0);
    check("t1_no_valid", dv_cnt - d0, 0);

    // 2: single channel 0
    ch_en = 4'b0001;
    push(2'd0);
    pulse_start();
    wait_idle("t2", 300);

    // 3: channels 1 and 3
    ch_en = 4'b1010;
    forbid = 4'b0101;
    push(2'd1); push(2'd3);
    pulse_start();
    wait_idle("t3", 400);
    forbid = 4'd0;
    check("t3_sel_viol", viol, 0);

    // 4: auto period, overruns during a long scan
    ch_en = 4'hF;
    o0 = ovr_cnt; r0 = rise_cyc.size();
    push(2'd0); push(2'd1); push(2'd2); push(2'd3);
    push(2'd0); push(2'd1); push(2'd2); push(2'd3);
    c0 = cyc;
    auto_r = 1'b1;
    for (int i = 0; i < 600 && rise_cyc.size() < r0 + 2; i++) @(negedge clk);
    auto_r = 1'b0;
    check("t4_two_scans", rise_cyc.size() - r0, 2);
    if (rise_cyc.size() >= r0 + 2) begin
      check("t4_first_start", rise_cyc[r0] - c0, PER);
      check("t4_restart_gap", rise_cyc[r0 + 1] - rise_cyc[r0], 300);
    end
    wait_idle("t4", 800);
    check("t4_overruns", ovr_cnt - o0, 5);

    // 5: empty mask ignored, mask change mid-scan ignored
    ch_en = 4'd0;
    o0 = ovr_cnt; r0 = rise_cyc.size();
    pulse_start();
    check("t5_busy_idle", busy, 1'b0);
    check("t5_csn_idle", ad[1], 1'b1);
    repeat (3) @(negedge clk);
    check("t5_no_scan", rise_cyc.size() - r0, 0);
    check("t5_no_overrun", ovr_cnt - o0, 0);
    ch_en = 4'b0001;
    forbid = 4'b1110;
    push(2'd0);
    pulse_start();
    repeat (10) @(negedge clk);
    ch_en = 4'b0100;
    wait_idle("t5", 300);
    forbid = 4'd0;
    check("t5_sel_viol", viol, 0);

    // 6: start coincides with timer expiry
    ch_en = 4'b0001;
    o0 = ovr_cnt; r0 = rise_cyc.size();
    push(2'd0);
    auto_r = 1'b1;
    repeat (PER - 1) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; auto_r = 1'b0;
    wait_idle("t6", 300);
    repeat (20) @(negedge clk);
    check("t6_one_scan", rise_cyc.size() - r0, 1);
    check("t6_no_overrun", ovr_cnt - o0, 0);
    check("sb_empty", sbq.size(), 0);
    check("clk_when_csn_high", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
